// File: rtl/aes_param_pkg.sv
`default_nettype none
// ============================================================================
// Module : aes_param_pkg
// Brief  : Shared encodings and GF(2^8) helpers for the parametrised AES
//          encipher round engine (key lengths, round counts, FSM states,
//          state-register update selects, shiftrows/mixcolumns functions).
// Rev    : 1.0  initial release
// ============================================================================
package aes_param_pkg;

   // Key length encodings as seen on the keylen port (2'b11 behaves as AES-128)
   localparam logic [1:0] c_KEYLEN_128 = 2'b00;
   localparam logic [1:0] c_KEYLEN_256 = 2'b01;
   localparam logic [1:0] c_KEYLEN_192 = 2'b10;

   // Number of rounds per key length
   localparam logic [3:0] c_NR_128 = 4'd10;
   localparam logic [3:0] c_NR_192 = 4'd12;
   localparam logic [3:0] c_NR_256 = 4'd14;

   // Control FSM states
   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_INIT = 2'd1;
   localparam logic [1:0] c_ST_SBOX = 2'd2;
   localparam logic [1:0] c_ST_MAIN = 2'd3;

   // State register update selects
   localparam logic [2:0] c_UPD_NONE  = 3'd0;
   localparam logic [2:0] c_UPD_INIT  = 3'd1;
   localparam logic [2:0] c_UPD_SBOX  = 3'd2;
   localparam logic [2:0] c_UPD_MAIN  = 3'd3;
   localparam logic [2:0] c_UPD_FINAL = 3'd4;
   localparam logic [2:0] c_UPD_CLEAR = 3'd5;

   function automatic logic [3:0] num_rounds(input logic [1:0] kl);
      case (kl)
         c_KEYLEN_256: return c_NR_256;
         c_KEYLEN_192: return c_NR_192;
         default:      return c_NR_128;
      endcase
   endfunction

   function automatic logic [7:0] gm2(input logic [7:0] op);
      return {op[6:0], 1'b0} ^ (8'h1b & {8{op[7]}});
   endfunction

   function automatic logic [7:0] gm3(input logic [7:0] op);
      return gm2(op) ^ op;
   endfunction

   // One column of MixColumns; byte 0 (row 0) sits in the MSBs
   function automatic logic [31:0] mixw(input logic [31:0] w);
      logic [7:0] b0, b1, b2, b3;
      b0 = w[31:24];
      b1 = w[23:16];
      b2 = w[15:8];
      b3 = w[7:0];
      return {gm2(b0) ^ gm3(b1) ^ b2 ^ b3,
              b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
              b0 ^ b1 ^ gm2(b2) ^ gm3(b3),
              gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
   endfunction

   // State is {w0,w1,w2,w3}, each word one column; row r rotates left by r
   function automatic logic [127:0] shiftrows(input logic [127:0] s);
      logic [31:0] w0, w1, w2, w3;
      w0 = s[127:96];
      w1 = s[95:64];
      w2 = s[63:32];
      w3 = s[31:0];
      return {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
              w1[31:24], w2[23:16], w3[15:8], w0[7:0],
              w2[31:24], w3[23:16], w0[15:8], w1[7:0],
              w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_logic.sv
`default_nettype none
// ============================================================================
// Module : aes_round_logic
// Brief  : Combinational round datapath. Produces the three AddRoundKey
//          candidates for the state register: initial (block ^ key), main
//          (mixcolumns(shiftrows(state)) ^ key) and final (shiftrows ^ key).
// Rev    : 1.0  initial release
// ============================================================================
module aes_round_logic
   import aes_param_pkg::*;
(
   input  logic [127:0] i_state,
   input  logic [127:0] i_round_key,
   input  logic [127:0] i_block,
   output logic [127:0] o_init_block,
   output logic [127:0] o_main_block,
   output logic [127:0] o_final_block
);

   logic [127:0] w_shifted;
   logic [127:0] w_mixed;

   assign w_shifted = shiftrows(i_state);

   assign w_mixed = {mixw(w_shifted[127:96]), mixw(w_shifted[95:64]),
                     mixw(w_shifted[63:32]),  mixw(w_shifted[31:0])};

   assign o_init_block  = i_block   ^ i_round_key;
   assign o_main_block  = w_mixed   ^ i_round_key;
   assign o_final_block = w_shifted ^ i_round_key;

endmodule
`default_nettype wire

// File: rtl/aes_param_encipher_block.sv
`default_nettype none
// ============================================================================
// Module : aes_param_encipher_block
// Brief  : Iterative AES encipher engine (AES-128/192/256) with an external
//          S-box bank of SBOX_LANES words per cycle and an external round-key
//          store addressed by the round output. Optional abort input is
//          built when the macro AES_ENC_ABORT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module aes_param_encipher_block
   import aes_param_pkg::*;
#(
   parameter int SBOX_LANES = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     next,
`ifdef AES_ENC_ABORT_EN
   input  logic                     abort,
`endif
   input  logic [1:0]               keylen,
   output logic [3:0]               round,
   input  logic [127:0]             round_key,
   output logic [32*SBOX_LANES-1:0] sboxw,
   input  logic [32*SBOX_LANES-1:0] new_sboxw,
   input  logic [127:0]             block,
   output logic [127:0]             new_block,
   output logic                     ready,
   output logic                     done
);

   generate
      if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_bad_lanes
         $error("aes_param_encipher_block: SBOX_LANES must be 1, 2 or 4");
      end
   endgenerate

   // Number of SBOX cycles needed to substitute all four state words
   localparam int         c_SBOX_CYCLES = (SBOX_LANES == 4) ? 1 : (SBOX_LANES == 2) ? 2 : 4;
   localparam logic [1:0] c_SWORD_LAST  = 2'(c_SBOX_CYCLES - 1);

   logic [1:0]   state_q, state_d;
   logic [127:0] block_q, block_d;
   logic [3:0]   round_ctr_q, round_ctr_d;
   logic [1:0]   sword_ctr_q, sword_ctr_d;
   logic [1:0]   keylen_q, keylen_d;
   logic         ready_q, ready_d;
   logic         done_q, done_d;

   logic [2:0]                w_upd;
   logic [3:0]                w_nr;
   logic [127:0]              w_init_block;
   logic [127:0]              w_main_block;
   logic [127:0]              w_final_block;
   logic [127:0]              w_sbox_block;
   logic [32*SBOX_LANES-1:0]  w_sbox_lanes;

   // State word handled by lane k during substitution group grp
   function automatic logic [1:0] word_idx(input logic [1:0] grp, input int k);
      return 2'(int'(grp) * SBOX_LANES + k);
   endfunction

   assign w_nr = num_rounds(keylen_q);

   aes_round_logic u_round_logic (
      .i_state       (block_q),
      .i_round_key   (round_key),
      .i_block       (block),
      .o_init_block  (w_init_block),
      .o_main_block  (w_main_block),
      .o_final_block (w_final_block)
   );

   // Route the current word group to the S-box lanes and merge results back
   always_comb begin
      w_sbox_lanes = '0;
      w_sbox_block = block_q;
      for (int k = 0; k < SBOX_LANES; k++) begin
         w_sbox_lanes[32*k +: 32] = block_q[127 - 32*int'(word_idx(sword_ctr_q, k)) -: 32];
         w_sbox_block[127 - 32*int'(word_idx(sword_ctr_q, k)) -: 32] = new_sboxw[32*k +: 32];
      end
   end

   // Control FSM: sequencing of INIT, SBOX groups and MAIN/FINAL updates
   always_comb begin
      state_d     = state_q;
      round_ctr_d = round_ctr_q;
      sword_ctr_d = sword_ctr_q;
      keylen_d    = keylen_q;
      ready_d     = ready_q;
      done_d      = 1'b0;
      w_upd       = c_UPD_NONE;
      case (state_q)
         c_ST_IDLE: begin
            if (next) begin
               round_ctr_d = 4'd0;
               keylen_d    = keylen;
               ready_d     = 1'b0;
               state_d     = c_ST_INIT;
            end
         end
         c_ST_INIT: begin
            w_upd       = c_UPD_INIT;
            round_ctr_d = round_ctr_q + 4'd1;
            sword_ctr_d = 2'd0;
            state_d     = c_ST_SBOX;
         end
         c_ST_SBOX: begin
            w_upd = c_UPD_SBOX;
            if (sword_ctr_q == c_SWORD_LAST) begin
               sword_ctr_d = 2'd0;
               state_d     = c_ST_MAIN;
            end else begin
               sword_ctr_d = sword_ctr_q + 2'd1;
            end
         end
         c_ST_MAIN: begin
            if (round_ctr_q < w_nr) begin
               w_upd       = c_UPD_MAIN;
               round_ctr_d = round_ctr_q + 4'd1;
               state_d     = c_ST_SBOX;
            end else begin
               w_upd   = c_UPD_FINAL;
               ready_d = 1'b1;
               done_d  = 1'b1;
               state_d = c_ST_IDLE;
            end
         end
         default: state_d = c_ST_IDLE;
      endcase
`ifdef AES_ENC_ABORT_EN
      // Abort overrides everything, including the final round update
      if (abort && (state_q != c_ST_IDLE)) begin
         w_upd       = c_UPD_CLEAR;
         round_ctr_d = 4'd0;
         sword_ctr_d = 2'd0;
         ready_d     = 1'b1;
         done_d      = 1'b0;
         state_d     = c_ST_IDLE;
      end
`endif
   end

   // State register next-value select
   always_comb begin
      block_d = block_q;
      case (w_upd)
         c_UPD_INIT:  block_d = w_init_block;
         c_UPD_SBOX:  block_d = w_sbox_block;
         c_UPD_MAIN:  block_d = w_main_block;
         c_UPD_FINAL: block_d = w_final_block;
         c_UPD_CLEAR: block_d = '0;
         default:     block_d = block_q;
      endcase
   end

   // Registers with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= c_ST_IDLE;
         block_q     <= '0;
         round_ctr_q <= 4'd0;
         sword_ctr_q <= 2'd0;
         keylen_q    <= c_KEYLEN_128;
         ready_q     <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         block_q     <= block_d;
         round_ctr_q <= round_ctr_d;
         sword_ctr_q <= sword_ctr_d;
         keylen_q    <= keylen_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
      end
   end

   assign round     = round_ctr_q;
   assign sboxw     = (state_q == c_ST_SBOX) ? w_sbox_lanes : '0;
   assign new_block = block_q;
   assign ready     = ready_q;
   assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_param_encipher_block.sv
`default_nettype none
// ============================================================================
// Module : tb_aes_param_encipher_block
// Brief  : Directed bench for aes_param_encipher_block with 1, 2 and 4 S-box
//          lanes, using FIPS-197 vectors, a behavioural S-box and key
//          expansion. Abort scenario is built when AES_ENC_ABORT_EN is set.
// Rev    : 1.0  initial release
// ============================================================================
module tb_aes_param_encipher_block;

   localparam logic [127:0] c_PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] c_K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] c_K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] c_K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] c_CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] c_CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] c_CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [1:0]   keylen = 2'b00;
   logic [127:0] block = '0;
   logic         next1 = 1'b0, next2 = 1'b0, next4 = 1'b0;
`ifdef AES_ENC_ABORT_EN
   logic         abort = 1'b0;
`endif

   logic [3:0]   round1, round2, round4;
   logic [127:0] rk1, rk2, rk4;
   logic [31:0]  sb1, nsb1;
   logic [63:0]  sb2, nsb2;
   logic [127:0] sb4, nsb4;
   logic [127:0] nb1, nb2, nb4;
   logic         rdy1, rdy2, rdy4;
   logic         dn1, dn2, dn4;

   logic [127:0] rk_tab [0:15];
   int           dcnt1 = 0, dcnt2 = 0, dcnt4 = 0;
   int           n_checks = 0;
   int           n_errors = 0;

   always #5 clk = ~clk;

   // ---------------- behavioural AES helpers ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xt(x);
         y = y >> 1;
      end
      return p;
   endfunction

   // S-box as multiplicative inverse (x^254) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] v);
      logic [7:0]  r, base, e;
      logic [15:0] t;
      r = 8'h01; base = v; e = 8'hfe;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = gmul(r, base);
         base = gmul(base, base);
      end
      t = {r, r};
      return r ^ t[14:7] ^ t[13:6] ^ t[12:5] ^ t[11:4] ^ 8'h63;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   task automatic expand_key(input logic [255:0] key, input logic [1:0] kl);
      logic [31:0] w [0:59];
      logic [31:0] tmp;
      logic [7:0]  rc;
      int nk, nr;
      case (kl)
         2'b01:   nk = 8;
         2'b10:   nk = 6;
         default: nk = 4;
      endcase
      nr = nk + 6;
      for (int i = 0; i < 60; i++) w[i] = '0;
      for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
      rc = 8'h01;
      for (int i = nk; i < 4*(nr+1); i++) begin
         tmp = w[i-1];
         if (i % nk == 0) begin
            tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
            rc  = xt(rc);
         end else if (nk == 8 && i % nk == 4) begin
            tmp = subw(tmp);
         end
         w[i] = w[i-nk] ^ tmp;
      end
      for (int r = 0; r < 16; r++)
         rk_tab[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
   endtask

   // ---------------- external key store and S-box bank ----------------
   assign rk1  = rk_tab[round1];
   assign rk2  = rk_tab[round2];
   assign rk4  = rk_tab[round4];
   assign nsb1 = subw(sb1);
   assign nsb2 = {subw(sb2[63:32]), subw(sb2[31:0])};
   assign nsb4 = {subw(sb4[127:96]), subw(sb4[95:64]), subw(sb4[63:32]), subw(sb4[31:0])};

   aes_param_encipher_block #(.SBOX_LANES(1)) u_l1 (
      .clk(clk), .reset(reset), .next(next1),
`ifdef AES_ENC_ABORT_EN
      .abort(1'b0),
`endif
      .keylen(keylen), .round(round1), .round_key(rk1), .sboxw(sb1), .new_sboxw(nsb1),
      .block(block), .new_block(nb1), .ready(rdy1), .done(dn1));

   aes_param_encipher_block #(.SBOX_LANES(2)) u_l2 (
      .clk(clk), .reset(reset), .next(next2),
`ifdef AES_ENC_ABORT_EN
      .abort(1'b0),
`endif
      .keylen(keylen), .round(round2), .round_key(rk2), .sboxw(sb2), .new_sboxw(nsb2),
      .block(block), .new_block(nb2), .ready(rdy2), .done(dn2));

   aes_param_encipher_block #(.SBOX_LANES(4)) u_l4 (
      .clk(clk), .reset(reset), .next(next4),
`ifdef AES_ENC_ABORT_EN
      .abort(abort),
`endif
      .keylen(keylen), .round(round4), .round_key(rk4), .sboxw(sb4), .new_sboxw(nsb4),
      .block(block), .new_block(nb4), .ready(rdy4), .done(dn4));

   // Count done pulses per instance
   always @(negedge clk) begin
      if (dn1) dcnt1 <= dcnt1 + 1;
      if (dn2) dcnt2 <= dcnt2 + 1;
      if (dn4) dcnt4 <= dcnt4 + 1;
   end

   // ---------------- checking and access helpers ----------------
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] get_nb(input int l);
      case (l)
         1:       return nb1;
         2:       return nb2;
         default: return nb4;
      endcase
   endfunction

   function automatic logic get_done(input int l);
      case (l)
         1:       return dn1;
         2:       return dn2;
         default: return dn4;
      endcase
   endfunction

   function automatic logic get_ready(input int l);
      case (l)
         1:       return rdy1;
         2:       return rdy2;
         default: return rdy4;
      endcase
   endfunction

   function automatic int get_dcnt(input int l);
      case (l)
         1:       return dcnt1;
         2:       return dcnt2;
         default: return dcnt4;
      endcase
   endfunction

   task automatic set_next(input int l, input logic v);
      case (l)
         1:       next1 = v;
         2:       next2 = v;
         default: next4 = v;
      endcase
   endtask

   // One encryption; cycle 0 is the cycle in which next is presented
   task automatic run_op(input string tag, input int l, input logic [1:0] kl,
                         input logic [255:0] key, input logic [127:0] ct,
                         input int lat, input bit disturb);
      int cyc, d0;
      bit seen;
      expand_key(key, kl);
      @(negedge clk);
      #1;
      block = c_PT;
      keylen = kl;
      set_next(l, 1'b1);
      d0 = get_dcnt(l);
      cyc = 0;
      seen = 1'b0;
      while (!seen && cyc < 400) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 1) set_next(l, 1'b0);
         if (disturb) begin
            if (cyc == 5) begin keylen = 2'b01; set_next(l, 1'b1); end
            if (cyc == 6) set_next(l, 1'b0);
            if (cyc == 10) keylen = 2'b10;
         end
         seen = get_done(l);
      end
      check({tag, "_latency"}, 128'(cyc), 128'(lat));
      check({tag, "_ct"}, get_nb(l), ct);
      check({tag, "_ready"}, 128'(get_ready(l)), 128'd1);
      @(negedge clk);
      @(negedge clk);
      #1;
      check({tag, "_done_pulses"}, 128'(get_dcnt(l) - d0), 128'd1);
      check({tag, "_done_low"}, 128'(get_done(l)), 128'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cyc, first, second, d0;

      for (int r = 0; r < 16; r++) rk_tab[r] = '0;
      repeat (2) @(negedge clk);

      // Reset values while reset is held
      check("rst_new_block", nb1, 128'h0);
      check("rst_round", 128'(round1), 128'd0);
      check("rst_ready", 128'(rdy1), 128'd1);
      check("rst_done", 128'(dn1), 128'd0);
      check("rst_sboxw", 128'(sb1), 128'h0);
      check("rst_l4_state", nb4, 128'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      run_op("aes128_l1", 1, 2'b00, c_K128, c_CT128, 52, 1'b0);
      check("idle_sboxw", 128'(sb1), 128'h0);
      run_op("aes192_l4", 4, 2'b10, c_K192, c_CT192, 26, 1'b0);
      run_op("aes256_l4", 4, 2'b01, c_K256, c_CT256, 30, 1'b0);
      run_op("aes128_l2_disturb", 2, 2'b00, c_K128, c_CT128, 32, 1'b1);
      run_op("keylen11_l4", 4, 2'b11, c_K128, c_CT128, 22, 1'b0);

      // Back-to-back: next held high across the done pulse
      expand_key(c_K128, 2'b00);
      @(negedge clk);
      #1;
      block = c_PT;
      keylen = 2'b00;
      next4 = 1'b1;
      d0 = dcnt4;
      cyc = 0; first = 0; second = 0;
      while (second == 0 && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         if (dn4) begin
            if (first == 0) begin
               first = cyc;
               check("b2b_ct1", nb4, c_CT128);
            end else begin
               second = cyc;
               check("b2b_ct2", nb4, c_CT128);
            end
         end
         if (first != 0 && cyc == first + 1) next4 = 1'b0;
      end
      next4 = 1'b0;
      check("b2b_lat1", 128'(first), 128'd22);
      check("b2b_lat2", 128'(second), 128'd44);
      @(negedge clk);
      @(negedge clk);
      #1;
      check("b2b_done_pulses", 128'(dcnt4 - d0), 128'd2);

      // Reset in the middle of an AES-256 run
      expand_key(c_K256, 2'b01);
      @(negedge clk);
      #1;
      block = c_PT;
      keylen = 2'b01;
      next1 = 1'b1;
      d0 = dcnt1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) next1 = 1'b0;
      end
      check("midrst_busy", 128'(rdy1), 128'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_new_block", nb1, 128'h0);
      check("midrst_ready", 128'(rdy1), 128'd1);
      check("midrst_round", 128'(round1), 128'd0);
      @(posedge clk);
      #1;
      check("midrst_done", 128'(dn1), 128'd0);
      check("midrst_hold_block", nb1, 128'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_no_pulse", 128'(dcnt1 - d0), 128'd0);
      run_op("aes256_l1_after_rst", 1, 2'b01, c_K256, c_CT256, 72, 1'b0);

`ifdef AES_ENC_ABORT_EN
      // Abort coincident with the final MAIN cycle
      expand_key(c_K128, 2'b00);
      @(negedge clk);
      #1;
      block = c_PT;
      keylen = 2'b00;
      next4 = 1'b1;
      d0 = dcnt4;
      for (int c = 1; c <= 21; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) next4 = 1'b0;
      end
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort_done", 128'(dn4), 128'd0);
      check("abort_ready", 128'(rdy4), 128'd1);
      check("abort_block", nb4, 128'h0);
      @(negedge clk);
      @(negedge clk);
      #1;
      check("abort_no_pulse", 128'(dcnt4 - d0), 128'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Absolute time bound for the whole run
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
